// File: rtl/sprite_sequencer.sv
// rtl/sprite_sequencer.sv - walks a sprite descriptor table once per frame and drives sprite_render.
// Optional watchdog on the render wait: define SPRITE_SEQ_TIMEOUT_EN.
module sprite_sequencer #(
  parameter int CORDW       = 10,
  parameter int MAX_SPRITES = 16,
  parameter int SPR_ID_W    = 4,
  parameter int TIMEOUT_CYC = 70000
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_frame_start,
  input  logic                                i_wr_en,
  input  logic [$clog2(MAX_SPRITES)-1:0]      i_wr_idx,
  input  logic [1+SPR_ID_W+8+2*CORDW-1:0]     i_wr_data,
  output logic                                o_render_rst,
  output logic                                o_render_enable,
  output logic [CORDW-1:0]                    o_sx,
  output logic [CORDW-1:0]                    o_sy,
  output logic [7:0]                          o_sprite_scale,
  output logic [SPR_ID_W-1:0]                 o_sprite_id,
  input  logic                                i_render_finished,
`ifdef SPRITE_SEQ_TIMEOUT_EN
  output logic                                o_timeout_err,
`endif
  output logic                                o_busy,
  output logic                                o_frame_done,
  output logic [$clog2(MAX_SPRITES)-1:0]      o_cur_idx
);

  localparam int IDXW = $clog2(MAX_SPRITES);
  localparam int DW   = 1 + SPR_ID_W + 8 + 2 * CORDW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [MAX_SPRITES-1:0] r_valid;
  logic [DW-2:0]          r_desc [MAX_SPRITES];
  logic [DW-2:0]          w_entry;
  logic [CORDW-1:0]       w_x;
  logic [CORDW-1:0]       w_y;
  logic [7:0]             w_scale;
  logic [SPR_ID_W-1:0]    w_id;
  logic                   w_live;
  logic                   w_last;
  logic                   w_abort;

  // Only the valid bits need a reset; payload fields are don't-care until written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_data[DW-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_desc[i_wr_idx] <= i_wr_data[DW-2:0];
    end
  end

  assign w_entry = r_desc[o_cur_idx];
  assign w_x     = w_entry[CORDW-1:0];
  assign w_y     = w_entry[2*CORDW-1:CORDW];
  assign w_scale = w_entry[2*CORDW+7:2*CORDW];
  assign w_id    = w_entry[2*CORDW+8+SPR_ID_W-1:2*CORDW+8];
  assign w_live  = r_valid[o_cur_idx] && (w_scale != 8'd0);
  assign w_last  = (o_cur_idx == IDXW'(MAX_SPRITES - 1));

`ifdef SPRITE_SEQ_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] r_tcnt;
  logic           w_tmo_hit;
  assign w_tmo_hit = (r_tcnt == TCW'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:  if (i_frame_start) w_next = S_FETCH;
      S_FETCH: w_next = w_live ? S_SETUP : S_NEXT;
      S_SETUP: w_next = S_RUN;
      S_RUN: begin
        if (i_render_finished) begin
          w_next = S_NEXT;
        end
`ifdef SPRITE_SEQ_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_next  = S_NEXT;
          w_abort = 1'b1;
        end
`endif
      end
      S_NEXT:  w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      o_render_rst    <= 1'b1;
      o_render_enable <= 1'b0;
      o_sx            <= '0;
      o_sy            <= '0;
      o_sprite_scale  <= '0;
      o_sprite_id     <= '0;
      o_busy          <= 1'b0;
      o_frame_done    <= 1'b0;
      o_cur_idx       <= '0;
    end else begin
      r_state         <= w_next;
      o_render_rst    <= (w_next != S_RUN);
      o_render_enable <= (w_next == S_RUN);
      o_busy          <= (w_next != S_IDLE);
      o_frame_done    <= (w_next == S_DONE);
      if (r_state == S_IDLE && i_frame_start) begin
        o_cur_idx <= '0;
      end else if (r_state == S_NEXT && !w_last) begin
        o_cur_idx <= o_cur_idx + 1'b1;
      end
      if (r_state == S_FETCH && w_live) begin
        o_sx           <= w_x;
        o_sy           <= w_y;
        o_sprite_scale <= w_scale;
        o_sprite_id    <= w_id;
      end
    end
  end

`ifdef SPRITE_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tcnt        <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_SETUP) begin
        r_tcnt <= '0;
      end else if (r_state == S_RUN) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_abort) begin
        o_timeout_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_sequencer.sv
// tb/tb_sprite_sequencer.sv - scoreboard bench for sprite_sequencer with a behavioural renderer.
module tb_sprite_sequencer;

  localparam int CORDW = 10;
  localparam int MAXS  = 16;
  localparam int IDW   = 4;
  localparam int IDXW  = 4;
  localparam int DW    = 1 + IDW + 8 + 2 * CORDW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic            wr_en = 1'b0;
  logic [IDXW-1:0] wr_idx = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            render_rst, render_enable, busy, frame_done;
  logic [CORDW-1:0] sx, sy;
  logic [7:0]      sprite_scale;
  logic [IDW-1:0]  sprite_id;
  logic [IDXW-1:0] cur_idx;
  logic            render_finished = 1'b0;
`ifdef SPRITE_SEQ_TIMEOUT_EN
  logic            timeout_err;
`endif

  sprite_sequencer #(
    .CORDW(CORDW), .MAX_SPRITES(MAXS), .SPR_ID_W(IDW)
`ifdef SPRITE_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start),
    .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
    .o_render_rst(render_rst), .o_render_enable(render_enable),
    .o_sx(sx), .o_sy(sy), .o_sprite_scale(sprite_scale), .o_sprite_id(sprite_id),
    .i_render_finished(render_finished),
`ifdef SPRITE_SEQ_TIMEOUT_EN
    .o_timeout_err(timeout_err),
`endif
    .o_busy(busy), .o_frame_done(frame_done), .o_cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_runs   = 0;
  int n_done   = 0;
  int n_rst_low = 0;
  int fin_delay = 256;
  logic [63:0] exp_q[$];

  logic        m_valid [MAXS];
  logic [IDW-1:0]   m_id [MAXS];
  logic [7:0]       m_scale [MAXS];
  logic [CORDW-1:0] m_x [MAXS];
  logic [CORDW-1:0] m_y [MAXS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input int idx, input logic v, input int id, input int scale,
                             input int y, input int x);
    m_valid[idx] = v;
    m_id[idx] = IDW'(id);
    m_scale[idx] = 8'(scale);
    m_y[idx] = CORDW'(y);
    m_x[idx] = CORDW'(x);
    wr_en = 1'b1;
    wr_idx = IDXW'(idx);
    wr_data = {v, m_id[idx], m_scale[idx], m_y[idx], m_x[idx]};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < MAXS; i++) write_entry(i, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic start_frame();
    for (int i = 0; i < MAXS; i++)
      if (m_valid[i] && m_scale[i] != 8'd0)
        exp_q.push_back(64'({IDXW'(i), m_id[i], m_scale[i], m_y[i], m_x[i]}));
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!frame_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!frame_done) check("frame_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_en();
    int c = 0;
    while (!render_enable && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (!render_enable) check("enable_timeout", 64'd0, 64'd1);
  endtask

  task automatic measure_run(output int len);
    len = 1;
    forever begin
      @(negedge clk);
      if (!render_enable || len > 5000) break;
      len++;
    end
  endtask

  // Behavioural sprite_render: raises finished after fin_delay enabled cycles, clears on render_rst.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (render_rst) begin
        render_finished = 1'b0;
        cnt = 0;
      end else if (render_enable) begin
        cnt++;
        if (cnt >= fin_delay) render_finished = 1'b1;
      end
    end
  end

  // Scoreboard: each render start is compared against the next expected descriptor.
  initial begin
    logic prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (render_enable && !prev_en) begin
        n_runs++;
        if (exp_q.size() == 0) check("unexpected_run", 64'd1, 64'd0);
        else check("render_desc", 64'({cur_idx, sprite_id, sprite_scale, sy, sx}), exp_q.pop_front());
      end
      if (frame_done) n_done++;
      if (!render_rst && !render_enable) n_rst_low++;
      prev_en = render_enable;
    end
  end

  initial begin
    int len, cyc, d0, r0;
    for (int i = 0; i < MAXS; i++) begin
      m_valid[i] = 1'b0; m_id[i] = '0; m_scale[i] = '0; m_x[i] = '0; m_y[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_render_rst", 64'(render_rst), 64'd1);
    check("rst_render_en", 64'(render_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_outs", 64'({cur_idx, sprite_id, sprite_scale, sy, sx}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single sprite, latency and 256-cycle render
    write_entry(0, 1'b1, 3, 16, 100, 200);
    fin_delay = 256;
    d0 = n_done;
    start_frame();
    check("fetch_busy", 64'(busy), 64'd1);
    check("fetch_en", 64'(render_enable), 64'd0);
    @(negedge clk);
    check("setup_rst", 64'(render_rst), 64'd1);
    check("setup_en", 64'(render_enable), 64'd0);
    @(negedge clk);
    check("run_en", 64'(render_enable), 64'd1);
    check("run_rst", 64'(render_rst), 64'd0);
    measure_run(len);
    check("run_len_256", 64'(len), 64'd256);
    wait_done(cyc);
    @(negedge clk);
    check("t1_done_once", 64'(n_done - d0), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);

    // Empty table: no renders, fixed walk length, render_rst never low
    clear_table();
    r0 = n_runs;
    n_rst_low = 0;
    start_frame();
    wait_done(cyc);
    check("empty_latency", 64'(cyc + 1), 64'(2 * MAXS + 1));
    check("empty_runs", 64'(n_runs - r0), 64'd0);
    check("empty_rst_low", 64'(n_rst_low), 64'd0);
    @(negedge clk);

    // Sparse table with a zero-scale entry
    write_entry(2, 1'b1, 1, 8, 20, 10);
    write_entry(5, 1'b1, 2, 32, 40, 30);
    write_entry(4, 1'b1, 7, 0, 60, 50);
    fin_delay = 5;
    r0 = n_runs;
    start_frame();
    wait_done(cyc);
    check("sparse_runs", 64'(n_runs - r0), 64'd2);
    check("sparse_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Re-pulse during RUN and overwrite current entry
    clear_table();
    write_entry(1, 1'b1, 9, 4, 33, 50);
    fin_delay = 40;
    d0 = n_done;
    start_frame();
    wait_en();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    write_entry(1, 1'b1, 9, 4, 33, 77);
    repeat (3) @(negedge clk);
    check("sx_held", 64'(sx), 64'd50);
    wait_done(cyc);
    repeat (5) @(negedge clk);
    check("repulse_done_once", 64'(n_done - d0), 64'd1);
    check("repulse_no_restart", 64'(busy), 64'd0);
    start_frame();
    wait_done(cyc);
    @(negedge clk);
    check("new_x_next_frame", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-RUN
    write_entry(3, 1'b1, 5, 2, 1, 2);
    fin_delay = 1000;
    start_frame();
    wait_en();
    #2 rst = 1'b1;
    #1;
    check("arst_en", 64'(render_enable), 64'd0);
    check("arst_rst", 64'(render_rst), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    for (int i = 0; i < MAXS; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    r0 = n_runs;
    start_frame();
    wait_done(cyc);
    check("arst_table_cleared", 64'(n_runs - r0), 64'd0);
    @(negedge clk);

`ifdef SPRITE_SEQ_TIMEOUT_EN
    write_entry(0, 1'b1, 1, 1, 5, 6);
    fin_delay = 1000000;
    start_frame();
    wait_en();
    measure_run(len);
    check("timeout_len", 64'(len), 64'd100);
    check("timeout_err_set", 64'(timeout_err), 64'd1);
    wait_done(cyc);
    @(negedge clk);
    check("timeout_err_sticky", 64'(timeout_err), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_sequencer.md
Name: sprite_sequencer

Overview:
- Upstream control stage for sprite_render.
- Holds a host-written sprite descriptor table and walks it once per frame on frame_start.
- For each live entry: presents position, scale and sprite id to the renderer, resets it, enables it, and waits for its finished flag.
- Pulses frame_done when the whole table has been drawn; the framebuffer swap logic consumes that pulse.

Parameters:
CORDW, 10, screen coordinate width (matches sprite_render)
MAX_SPRITES, 16, descriptor table depth (power of 2, >=2)
SPR_ID_W, 4, sprite id width (selects sprite ROM base)
TIMEOUT_CYC, 70000, watchdog limit in cycles (used only with SPRITE_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle pulse: begin walking the table
wr_en  in  1  descriptor table write strobe
wr_idx  in  $clog2(MAX_SPRITES)  descriptor index to write
wr_data  in  1+SPR_ID_W+8+2*CORDW  descriptor {valid, id, scale[7:0], y, x}; x is the LSBs
render_rst  out  1  synchronous reset to sprite_render
render_enable  out  1  enable to sprite_render
sx  out  CORDW  sprite screen x
sy  out  CORDW  sprite screen y
sprite_scale  out  8  scale byte to sprite_render
sprite_id  out  SPR_ID_W  sprite ROM select
render_finished  in  1  finished flag from sprite_render (level, held until render_rst)
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of a table walk
cur_idx  out  $clog2(MAX_SPRITES)  index currently being processed

Behaviour:
- All outputs are registered.
- Reset values: render_rst=1, render_enable=0, sx=sy=0, sprite_scale=0, sprite_id=0, busy=0, frame_done=0, cur_idx=0, state=IDLE.
- On reset, every table entry's valid bit is cleared; the other descriptor fields are don't-care.
- Table writes are accepted in every state and take effect on the next clk edge.
- The descriptor currently being drawn is latched in FETCH, so overwriting its entry mid-render does not disturb the current sprite.
- FSM states: IDLE, FETCH, SETUP, RUN, NEXT, DONE.
- IDLE:
  - render_rst=1, render_enable=0.
  - frame_start=1 → FETCH with cur_idx=0.
- FETCH:
  - Read entry[cur_idx].
  - If valid=1 and scale!=0: latch x, y, scale and id onto the outputs → SETUP.
  - Otherwise (invalid entry or scale=0) → NEXT; the renderer is never started for that entry.
- SETUP: render_rst=1 for exactly one cycle, render_enable=0 → RUN.
- RUN:
  - render_rst=0, render_enable=1.
  - When render_finished is sampled 1: render_enable=0 on the next cycle → NEXT.
  - render_finished is ignored in all states other than RUN.
- NEXT:
  - If cur_idx==MAX_SPRITES-1 → DONE.
  - Otherwise cur_idx+1 → FETCH.
  - cur_idx never wraps within a frame.
- DONE: frame_done=1 for one cycle, render_rst=1 → IDLE.
- Latency:
  - frame_start sampled at edge k → render_rst pulse at cycle k+2 → render_enable first high at cycle k+3.
  - Per skipped entry: 2 cycles (FETCH + NEXT).
- frame_start while busy=1 is ignored and not queued.
- frame_start arriving in the same cycle as the DONE→IDLE transition is also ignored.
- Asynchronous reset mid-RUN: render_enable drops and render_rst rises immediately; the FSM returns to IDLE and the table is invalidated.

Optional Feature:
SPRITE_SEQ_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC before render_finished is seen, the sprite is aborted: render_enable=0 → NEXT.
  - A sticky output port timeout_err (1 bit) is set; it clears only on rst.
- Undefined: no counter and no timeout_err port; RUN waits indefinitely for render_finished.

Test Plan:
- Reset, write entry 0 = {valid=1, id=3, scale=16, y=100, x=200}, pulse frame_start → render_rst high at cycle +2, render_enable high from cycle +3 with sx=200, sy=100, sprite_scale=16, sprite_id=3; drive render_finished after 256 cycles → render_enable low next cycle; all other entries invalid, so frame_done pulses exactly once.
- All entries invalid, frame_start → no render_rst pulse outside IDLE, render_enable never high; frame_done 2*MAX_SPRITES+1 cycles after FETCH entry (33 for default).
- Entries 2 and 5 valid with scale=8 and 32, entry 4 valid with scale=0 → exactly two render runs, in index order 2 then 5; entry 4 skipped.
- frame_start re-pulsed during RUN → no restart and a single frame_done; then overwrite the current entry's x mid-RUN → sx unchanged until the next frame.
- Assert rst asynchronously mid-RUN → render_enable=0 and render_rst=1 before the next clk edge; busy=0; a following frame_start draws nothing.
- With SPRITE_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, never assert render_finished → render_enable drops at 100 RUN cycles; timeout_err=1 and stays set; the walk continues to frame_done.
